// File: rtl/rv32i_types.sv
// Shared RV32I types: byte-lane mask constants and the dmem response-stage record.
// Used by dmem_responder (optional request checking under DMEM_RESP_CHECK_EN).
package rv32i_types;

    typedef logic [3:0] mask_byte_t;

    localparam mask_byte_t MASK_NONE = 4'b0000;
    localparam mask_byte_t MASK_WORD = 4'b1111;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } dmem_resp_stage_t;

    // Expand a byte mask into a 32-bit bit mask, one byte per mask bit.
    function automatic logic [31:0] mask_to_bits(input mask_byte_t mask);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem request/response bundle between the memory stage (master) and the responder (slave).
// Request checking in the responder is controlled by DMEM_RESP_CHECK_EN.
interface dmem_responder_if #(
    parameter int unsigned LATENCY = 2
);
    import rv32i_types::*;

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [31:0]      dmem_addr;
    mask_byte_t       dmem_rmask;
    mask_byte_t       dmem_wmask;
    logic [31:0]      dmem_wdata;
    logic [31:0]      dmem_rdata;
    logic             dmem_resp;
    logic             dmem_err;
    logic [CNT_W-1:0] outstanding;

    modport master (
        output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp, dmem_err, outstanding
    );

    modport slave (
        input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp, dmem_err, outstanding
    );

endinterface

// File: rtl/dmem_resp_pipe.sv
// Fixed-latency response delay line: LATENCY stages of {valid, err, rdata}, tail is the output.
// Independent of DMEM_RESP_CHECK_EN; errors ride through as data.
module dmem_resp_pipe
    import rv32i_types::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  dmem_resp_stage_t stage_i,
    output dmem_resp_stage_t stage_o
);

    dmem_resp_stage_t stage_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= stage_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign stage_o = stage_q[LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory answering byte-masked dmem requests after a fixed latency.
// Define DMEM_RESP_CHECK_EN to flag misaligned / out-of-range requests via dmem_err.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    import rv32i_types::*;

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic             req_valid;
    logic             req_err;
    logic             wr_en;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      wr_bits;
    dmem_resp_stage_t stage_in;
    dmem_resp_stage_t stage_out;
    logic [CNT_W-1:0] outstanding_q;

    assign req_valid = (bus.dmem_rmask | bus.dmem_wmask) != MASK_NONE;
    assign word_idx  = bus.dmem_addr[2 +: IDX_W];

`ifdef DMEM_RESP_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    assign req_err = req_valid &&
                     ((bus.dmem_addr[1:0] != 2'b00) || (bus.dmem_addr >= ADDR_LIMIT));
`else
    // Without checking the high bits wrap and the byte offset is ignored.
    logic unused_addr_bits;

    assign req_err          = 1'b0;
    assign unused_addr_bits = ^{bus.dmem_addr[31:IDX_W+2], bus.dmem_addr[1:0]};
`endif

    assign wr_en   = (bus.dmem_wmask != MASK_NONE) && !req_err;
    assign wr_bits = mask_to_bits(bus.dmem_wmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[word_idx] <= (mem_q[word_idx] & ~wr_bits) | (bus.dmem_wdata & wr_bits);
        end
    end

    // Read captures the pre-write word; masked-off lanes and errored requests return 0.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = req_valid;
        stage_in.err   = req_err;
        stage_in.rdata = req_err ? 32'h0 : (mem_q[word_idx] & mask_to_bits(bus.dmem_rmask));
    end

    dmem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .stage_i (stage_in),
        .stage_o (stage_out)
    );

    assign bus.dmem_resp  = stage_out.valid;
    assign bus.dmem_err   = stage_out.err;
    assign bus.dmem_rdata = stage_out.rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            unique case ({req_valid, stage_out.valid})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    assign bus.outstanding = outstanding_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder at the far end of the RV32I pipeline's dmem request interface. It accepts byte-masked read/write requests issued by the memory stage (dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata) and returns dmem_rdata with a dmem_resp strobe after a fixed pipelined latency. It holds a word-organised storage array and is used as the pipeline's data-memory model in simulation and as the template for the later cache-facing adapter.

## Interface
Parameters:
- DEPTH_WORDS, 256: storage words; power of two, ≥ 4.
- LATENCY, 2: cycles from request to response; ≥ 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dmem_addr  in  32  byte address, word-aligned by the requester.
- dmem_rmask  in  4  byte read mask; nonzero = read request.
- dmem_wmask  in  4  byte write mask; nonzero = write request.
- dmem_wdata  in  32  write data, byte lanes already positioned.
- dmem_rdata  out  32  read data, valid while dmem_resp = 1.
- dmem_resp  out  1  one-cycle response strobe, one per accepted request.
- dmem_err  out  1  error flag, qualified by dmem_resp.
- outstanding  out  $clog2(LATENCY+1)  accepted requests not yet responded.

## Operation
- Request valid in a cycle iff (dmem_rmask | dmem_wmask) != 0. Always accepted: one request per cycle, no back-pressure.
- Word index = dmem_addr[2 +: $clog2(DEPTH_WORDS)]; higher bits ignored (wrap) unless DMEM_RESP_CHECK_EN.
- Write: at acceptance edge, each byte lane i with dmem_wmask[i] = 1 takes dmem_wdata[8i+7:8i]; other lanes unchanged.
- Read: word sampled at acceptance edge (pre-write value if the same request also writes). Lanes with dmem_rmask[i] = 0 returned as 0.
- Combined rmask and wmask in one request is legal: read returns old data, write applies.
- Writes also produce a dmem_resp; dmem_rdata = 0 for write-only requests.
- Response pipeline: LATENCY-stage shift register of {valid, err, data}; tail stage drives outputs.
- outstanding: +1 on accepted request, −1 on dmem_resp; both in the same cycle → unchanged. Never exceeds LATENCY.

## Timing
- Request presented in cycle N → dmem_resp = 1 in cycle N+LATENCY, registered outputs.
- Back-to-back requests N, N+1, … → responses N+LATENCY, N+LATENCY+1, … in order, no bubbles.
- Write in cycle N visible to a read presented in cycle N+1 or later.
- Reset (any time, including mid-flight): all pipeline valid bits cleared, in-flight responses dropped, storage cleared to 0. Outputs during/after reset: dmem_rdata = 0, dmem_resp = 0, dmem_err = 0, outstanding = 0.
- First request accepted on the first rising edge with rst_n = 1.

## Configuration
- Macro DMEM_RESP_CHECK_EN.
- Defined: request errors if dmem_addr[1:0] != 0 or dmem_addr >= 4·DEPTH_WORDS. Errored request: no storage write, dmem_rdata = 0, dmem_err = 1 with its dmem_resp; latency unchanged.
- Undefined: no checking; high address bits wrap, low two bits ignored; dmem_err tied 0.

## Structure
- Shared package rv32i_types: byte-mask constants (mask_byte_t, MASK_WORD = 4'b1111) and the response-stage struct dmem_resp_stage_t {valid, err, rdata}.
- One sub-module: dmem_resp_pipe (parameterised LATENCY-deep shift register of dmem_resp_stage_t with async active-low reset). Storage and checking stay in dmem_responder.

## Test plan
- Reset then idle: rst_n low mid-sim for 3 cycles → dmem_resp = 0, outstanding = 0, subsequent read of addr 0x40 returns 0x00000000.
- Write 0xDEADBEEF mask 4'b1111 to 0x10 in cycle N, read mask 4'b1111 from 0x10 in N+1 → resp at N+LATENCY (rdata 0) and N+1+LATENCY (rdata 0xDEADBEEF).
- Byte write: word 0x10 = 0xDEADBEEF, write 0x0000AA00 mask 4'b0010, read mask 4'b0110 → rdata 0x00ADAA00.
- Back-to-back 8 reads at LATENCY = 3 → 8 consecutive dmem_resp cycles, in order; outstanding peaks at 3.
- Reset asserted with 2 responses in flight → neither response appears after release; outstanding = 0.
- With DMEM_RESP_CHECK_EN: write to 0x12 and to 4·DEPTH_WORDS → dmem_err = 1 on both responses, storage unchanged; without macro, write to 4·DEPTH_WORDS lands at word 0.
